// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one 8-bit ALU between NREQ requesters.
// Operands and results are registered so the ALU path sits between two flops.
module alu_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*8-1:0]   req_x,
    input  logic [NREQ*8-1:0]   req_y,
    input  logic [NREQ*3-1:0]   req_op,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [7:0]          rsp_result,
    output logic                rsp_overflow,
    output logic [ID_W-1:0]     rsp_id,
    output logic                busy,
    output logic [CNT_W-1:0]    ops_done
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_found;
    logic [ID_W:0]   cand;
    logic [7:0]      gnt_x, gnt_y;
    logic [2:0]      gnt_op;
    logic [7:0]      x_q, y_q;
    logic [2:0]      op_q;
    logic [7:0]      alu_r;
    logic            alu_ov;
    logic            rsp_hs;

    // Search upward from the pointer, wrapping at NREQ; first valid wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NREQ))
                cand = cand - (ID_W+1)'(NREQ);
            if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_x  = '0;
        gnt_y  = '0;
        gnt_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                gnt_x  = req_x[8*i +: 8];
                gnt_y  = req_y[8*i +: 8];
                gnt_op = req_op[3*i +: 3];
            end
        end
    end

    always_comb begin
        alu_r  = '0;
        alu_ov = 1'b0;
        case (op_q)
            3'b000: begin
                alu_r  = x_q + y_q;
                alu_ov = (x_q[7] == y_q[7]) && (alu_r[7] != x_q[7]);
            end
            3'b001: begin
                alu_r  = x_q - y_q;
                alu_ov = (x_q[7] != y_q[7]) && (alu_r[7] != x_q[7]);
            end
            3'b010: alu_r = ~x_q;
            3'b011: alu_r = x_q & y_q;
            3'b100: alu_r = x_q | y_q;
            3'b101: alu_r = x_q ^ y_q;
            3'b110: alu_r = {7'b0, (x_q > y_q)};
            3'b111: alu_r = {7'b0, (x_q == y_q)};
            default: alu_r = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        rsp_hs    = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    req_ready[gnt_id] = 1'b1;
                    state_nxt         = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_valid[rsp_id] = 1'b1;
                if (rsp_ready[rsp_id]) begin
                    rsp_hs    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Pointer only advances on a completed response, so a reset mid-flight leaves it at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            x_q          <= '0;
            y_q          <= '0;
            op_q         <= '0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            ops_done     <= '0;
        end else begin
            if (state == IDLE && gnt_found) begin
                x_q    <= gnt_x;
                y_q    <= gnt_y;
                op_q   <= gnt_op;
                rsp_id <= gnt_id;
            end
            if (state == EXEC) begin
                rsp_result   <= alu_r;
                rsp_overflow <= alu_ov;
            end
            if (rsp_hs) begin
                if (ops_done != '1)
                    ops_done <= ops_done + CNT_W'(1);
                ptr <= (rsp_id == ID_W'(NREQ-1)) ? '0 : rsp_id + ID_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler: a cycle-level reference model pushes
// expected responses on every grant; a separate monitor pops on each response.
module tb_alu_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*8-1:0]   req_x = '0;
    logic [NREQ*8-1:0]   req_y = '0;
    logic [NREQ*3-1:0]   req_op = '0;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready = '1;
    logic [7:0]          rsp_result;
    logic                rsp_overflow;
    logic [ID_W-1:0]     rsp_id;
    logic                busy;
    logic [CNT_W-1:0]    ops_done;

    alu_rr_scheduler #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_id(rsp_id),
        .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int result;
        int ov;
    } rsp_t;

    int   total = 0;
    int   bad = 0;
    rsp_t expQ[$];
    rsp_t resultLog[$];
    int   grantLog[$];

    int   mState = 0;
    int   mPtr = 0;
    int   mId = 0;
    int   mDone = 0;
    int   g;
    logic [NREQ-1:0] expReady, expValid;
    rsp_t mon;

    logic [NREQ-1:0] acceptMask = '0;
    logic [NREQ-1:0] contMask = '0;
    logic [NREQ-1:0] randMask = '0;
    logic [NREQ-1:0] rspReadyMask = '1;
    bit              randRsp = 1'b0;

    logic [NREQ-1:0]   holdPend = '0;
    logic [NREQ*8-1:0] prevX, prevY;
    logic [NREQ*3-1:0] prevOp;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: timed out", name);
    endtask

    // Reference ALU in plain signed/unsigned integer arithmetic.
    function automatic rsp_t aluRef(input int id, input int op, input int x, input int y);
        rsp_t r;
        int sx, sy, s;
        sx = (x >= 128) ? x - 256 : x;
        sy = (y >= 128) ? y - 256 : y;
        r.id = id;
        r.ov = 0;
        r.result = 0;
        case (op)
            0: begin s = sx + sy; r.result = (x + y) % 256;       r.ov = (s > 127 || s < -128); end
            1: begin s = sx - sy; r.result = (x - y + 256) % 256; r.ov = (s > 127 || s < -128); end
            2: r.result = 255 - x;
            3: r.result = x & y;
            4: r.result = x | y;
            5: r.result = x ^ y;
            6: r.result = (x > y) ? 1 : 0;
            default: r.result = (x == y) ? 1 : 0;
        endcase
        return r;
    endfunction

    function automatic int rrPick(input int ptr, input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic int firstOne(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: predicts handshakes cycle by cycle and feeds the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            mState = 0;
            mPtr = 0;
            mDone = 0;
            expQ.delete();
            acceptMask = '0;
        end else begin
            g = rrPick(mPtr, req_valid);
            expReady = (mState == 0 && g >= 0) ? (NREQ'(1) << g) : '0;
            expValid = (mState == 2) ? (NREQ'(1) << mId) : '0;
            checkOutput("req_ready", 32'(req_ready), 32'(expReady));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(expValid));
            checkOutput("busy", 32'(busy), 32'(mState != 0));
            checkOutput("ops_done", 32'(ops_done), mDone);
            acceptMask = req_valid & req_ready;
            if (req_ready != '0) grantLog.push_back(firstOne(req_ready));
            case (mState)
                0: if (g >= 0) begin
                    expQ.push_back(aluRef(g, int'(req_op[3*g +: 3]), int'(req_x[8*g +: 8]), int'(req_y[8*g +: 8])));
                    mId = g;
                    mState = 1;
                end
                1: mState = 2;
                default: if (rsp_ready[mId]) begin
                    if (mDone < 65535) mDone++;
                    mPtr = (mId + 1) % NREQ;
                    mState = 0;
                end
            endcase
        end
    end

    // Response monitor: compares every presented response against the queue head.
    always @(negedge clk) begin
        if (!rst && rsp_valid != '0) begin
            if (expQ.size() == 0) begin
                checkOutput("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
                mon = expQ[0];
                checkOutput("rsp_id", 32'(rsp_id), mon.id);
                checkOutput("rsp_result", 32'(rsp_result), mon.result);
                checkOutput("rsp_overflow", 32'(rsp_overflow), mon.ov);
                if ((rsp_valid & rsp_ready) != '0) begin
                    resultLog.push_back('{int'(rsp_id), int'(rsp_result), int'(rsp_overflow)});
                    void'(expQ.pop_front());
                end
            end
        end
    end

    // Requesters must hold valid and operands until accepted.
    always @(negedge clk) begin
        if (rst) begin
            holdPend = '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (holdPend[i])
                    assert (req_valid[i] && req_x[8*i +: 8] == prevX[8*i +: 8] &&
                            req_y[8*i +: 8] == prevY[8*i +: 8] && req_op[3*i +: 3] == prevOp[3*i +: 3])
                        else $error("[TB] requester %0d dropped or changed a pending request", i);
            holdPend = req_valid & ~req_ready;
            prevX = req_x;
            prevY = req_y;
            prevOp = req_op;
        end
    end

    task automatic randomOps(input int i);
        req_x[8*i +: 8]  = 8'($urandom);
        req_y[8*i +: 8]  = 8'($urandom);
        req_op[3*i +: 3] = 3'($urandom);
    endtask

    task automatic applyStimulus(output logic [NREQ-1:0] acc);
        @(posedge clk);
        #1;
        acc = acceptMask;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                if (contMask[i]) randomOps(i);
                else req_valid[i] = 1'b0;
            end else if (!req_valid[i] && randMask[i] && $urandom_range(0, 2) == 0) begin
                randomOps(i);
                req_valid[i] = 1'b1;
            end
        end
        rsp_ready = randRsp ? NREQ'($urandom) : rspReadyMask;
    endtask

    task automatic doReset();
        logic [NREQ-1:0] acc;
        rst = 1'b1;
        applyStimulus(acc);
        applyStimulus(acc);
        rst = 1'b0;
    endtask

    task automatic issueOp(input int i, input int op, input int x, input int y);
        logic [NREQ-1:0] acc;
        req_x[8*i +: 8]  = 8'(x);
        req_y[8*i +: 8]  = 8'(y);
        req_op[3*i +: 3] = 3'(op);
        req_valid[i] = 1'b1;
        for (int n = 0; n < 100; n++) begin
            applyStimulus(acc);
            if (acc[i]) return;
        end
        failNow("issue_accept");
    endtask

    task automatic waitIdle(input int limit);
        logic [NREQ-1:0] acc;
        for (int n = 0; n < limit; n++) begin
            applyStimulus(acc);
            if (mState == 0 && expQ.size() == 0 && req_valid == '0) return;
        end
        failNow("wait_idle");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [NREQ-1:0] acc;
        int grantTab[6];
        int sweepTab[6];
        bit seen;
        grantTab = '{0, 1, 2, 3, 0, 1};
        sweepTab = '{8'h5A, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h00};

        doReset();
        checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset_rsp_result", 32'(rsp_result), 32'h0);
        checkOutput("reset_rsp_overflow", 32'(rsp_overflow), 32'h0);
        checkOutput("reset_rsp_id", 32'(rsp_id), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_ops_done", 32'(ops_done), 32'h0);

        $display("[TB] directed single operations");
        resultLog.delete();
        issueOp(0, 0, 8'h7F, 8'h01);
        waitIdle(20);
        issueOp(2, 1, 8'h80, 8'h01);
        issueOp(2, 6, 8'h05, 8'h03);
        waitIdle(20);
        if (resultLog.size() == 3) begin
            checkOutput("add_result", resultLog[0].result, 32'h80);
            checkOutput("add_overflow", resultLog[0].ov, 1);
            checkOutput("add_id", resultLog[0].id, 0);
            checkOutput("sub_result", resultLog[1].result, 32'h7F);
            checkOutput("sub_overflow", resultLog[1].ov, 1);
            checkOutput("gt_result", resultLog[2].result, 32'h01);
            checkOutput("gt_overflow", resultLog[2].ov, 0);
        end else begin
            checkOutput("directed_count", resultLog.size(), 3);
        end
        checkOutput("directed_ops_done", 32'(ops_done), 3);

        $display("[TB] all requesters continuously valid");
        rst = 1'b1;
        contMask = '1;
        for (int i = 0; i < NREQ; i++) randomOps(i);
        req_valid = '1;
        applyStimulus(acc);
        applyStimulus(acc);
        rst = 1'b0;
        grantLog.delete();
        resultLog.delete();
        for (int n = 0; n < 60 && mDone < 6; n++) applyStimulus(acc);
        checkOutput("rr_ops_done", 32'(ops_done), 6);
        if (grantLog.size() >= 6 && resultLog.size() >= 6) begin
            for (int k = 0; k < 6; k++) begin
                checkOutput("rr_grant_order", grantLog[k], grantTab[k]);
                checkOutput("rr_rsp_id", resultLog[k].id, grantTab[k]);
            end
        end else begin
            checkOutput("rr_grant_count", grantLog.size(), 6);
        end
        contMask = '0;
        waitIdle(40);

        $display("[TB] response back-pressure");
        doReset();
        rspReadyMask = 4'b1101;
        issueOp(1, $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            applyStimulus(acc);
            seen = rsp_valid[1];
        end
        if (!seen) failNow("bp_rsp_valid");
        randomOps(0);
        req_valid[0] = 1'b1;
        for (int n = 0; n < 5; n++) begin
            applyStimulus(acc);
            checkOutput("bp_busy", 32'(busy), 1);
            checkOutput("bp_req_ready", 32'(req_ready), 32'h0);
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'h2);
        end
        rspReadyMask = '1;
        applyStimulus(acc);
        applyStimulus(acc);
        checkOutput("bp_release_busy", 32'(busy), 0);
        checkOutput("bp_release_grant", 32'(req_ready), 32'h1);
        waitIdle(20);

        $display("[TB] reset during execution");
        doReset();
        randomOps(3);
        req_valid[3] = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            applyStimulus(acc);
            seen = acc[3];
        end
        if (!seen) failNow("exec_rst_accept");
        rst = 1'b1;
        applyStimulus(acc);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            applyStimulus(acc);
            checkOutput("exec_rst_rsp_valid", 32'(rsp_valid), 32'h0);
            checkOutput("exec_rst_ops_done", 32'(ops_done), 32'h0);
        end
        randomOps(1);
        randomOps(3);
        grantLog.delete();
        req_valid = 4'b1010;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            applyStimulus(acc);
            seen = (acc != '0);
        end
        if (grantLog.size() > 0) checkOutput("exec_rst_next_grant", grantLog[0], 1);
        else failNow("exec_rst_next_grant");
        waitIdle(40);

        $display("[TB] opcode sweep");
        resultLog.delete();
        for (int op = 2; op < 8; op++) issueOp(0, op, 8'hA5, 8'h5A);
        waitIdle(20);
        if (resultLog.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                checkOutput("sweep_result", resultLog[k].result, sweepTab[k]);
                checkOutput("sweep_overflow", resultLog[k].ov, 0);
            end
        end else begin
            checkOutput("sweep_count", resultLog.size(), 6);
        end

        $display("[TB] randomized traffic");
        randMask = '1;
        randRsp = 1'b1;
        for (int n = 0; n < 1500; n++) applyStimulus(acc);
        randMask = '0;
        randRsp = 1'b0;
        rspReadyMask = '1;
        waitIdle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
